// File: rtl/clk_divider_prog.sv
// Programmable clock divider with glitch-free period/high-time reconfiguration.
// New settings wait in a shadow register and are applied only at a period boundary.
module clk_divider_prog #(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned DEFAULT_PERIOD = 50_000_000,
    parameter int unsigned DEFAULT_HIGH   = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_load,
    output logic             cfg_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] act_p_q, act_h_q;
    logic [CNT_W-1:0] shd_p_q, shd_h_q;
    logic             pend_q;
    logic             clk_out_q, tick_q, cfg_ack_q;

    logic [CNT_W-1:0] cap_p, cap_h;
    logic [CNT_W-1:0] cnt_d, h_d;
    logic             wrap;

    // Clamp requested config so the output always toggles (P>=2, 1<=H<=P-1).
    always_comb begin
        cap_p = (cfg_period < TWO) ? TWO : cfg_period;
        if (cfg_high == '0)
            cap_h = ONE;
        else if (cfg_high > cap_p - ONE)
            cap_h = cap_p - ONE;
        else
            cap_h = cfg_high;
    end

    // High time governing the period that starts at this edge if it is a wrap.
    always_comb begin
        wrap  = (cnt_q == act_p_q - ONE);
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (cfg_load)
            h_d = cap_h;
        else if (pend_q)
            h_d = shd_h_q;
        else
            h_d = act_h_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            act_p_q   <= DEF_P;
            act_h_q   <= DEF_H;
            shd_p_q   <= '0;
            shd_h_q   <= '0;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            cfg_ack_q <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            cfg_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    pend_q    <= 1'b0;
                    if (cfg_load) begin
                        act_p_q   <= cap_p;
                        act_h_q   <= cap_h;
                        cfg_ack_q <= 1'b1;
                    end
                    if (en) begin
                        state_q   <= RUN;
                        clk_out_q <= 1'b1;
                        tick_q    <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    cnt_q <= cnt_d;
                    if (wrap) begin
                        // A load coinciding with the wrap bypasses the shadow.
                        if (cfg_load) begin
                            act_p_q   <= cap_p;
                            act_h_q   <= cap_h;
                            cfg_ack_q <= 1'b1;
                        end else if (pend_q) begin
                            act_p_q   <= shd_p_q;
                            act_h_q   <= shd_h_q;
                            cfg_ack_q <= 1'b1;
                        end
                        pend_q <= 1'b0;
                        if (state_q == STOP && !en) begin
                            state_q   <= IDLE;
                            clk_out_q <= 1'b0;
                        end else begin
                            state_q   <= en ? RUN : STOP;
                            clk_out_q <= (cnt_d < h_d);
                            tick_q    <= 1'b1;
                        end
                    end else begin
                        if (cfg_load) begin
                            shd_p_q <= cap_p;
                            shd_h_q <= cap_h;
                            pend_q  <= 1'b1;
                        end
                        clk_out_q <= (cnt_d < act_h_q);
                        state_q   <= en ? RUN : STOP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_ack = cfg_ack_q;
    assign running = (state_q != IDLE);

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: per-cycle expected clk_out/tick/cfg_ack/running
// patterns written out by hand for each scenario.
module tb_clk_divider_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       cfg_load;
    logic       cfg_ack;
    logic       clk_out;
    logic       tick;
    logic       running;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    clk_divider_prog #(
        .CNT_W         (8),
        .DEFAULT_PERIOD(4),
        .DEFAULT_HIGH  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_load  (cfg_load),
        .cfg_ack   (cfg_ack),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [7:0] h);
        cfg_period = p;
        cfg_high   = h;
        cfg_load   = 1'b1;
    endtask

    // Advance n cycles; pattern bit [n-1] is the first cycle after the first edge.
    task automatic run_seq(input string tag, input int n, input logic [15:0] ck,
                           input logic [15:0] tk, input logic [15:0] ak, input logic [15:0] rn);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cfg_load = 1'b0;
            chk($sformatf("%s[%0d].clk_out", tag, i), 32'(clk_out), 32'(ck[n-1-i]));
            chk($sformatf("%s[%0d].tick", tag, i),    32'(tick),    32'(tk[n-1-i]));
            chk($sformatf("%s[%0d].cfg_ack", tag, i), 32'(cfg_ack), 32'(ak[n-1-i]));
            chk($sformatf("%s[%0d].running", tag, i), 32'(running), 32'(rn[n-1-i]));
            $display("%s cyc=%0d clk_out=%0b tick=%0b ack=%0b run=%0b",
                     tag, i, clk_out, tick, cfg_ack, running);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_period = '0; cfg_high = '0;
        run_seq("reset", 2, 16'b00, 16'b00, 16'b00, 16'b00);
        reset = 1'b0;

        // Default divide-by-4, 50% duty
        en = 1'b1;
        run_seq("run_default", 8, 16'b11001100, 16'b10001000, 16'b0, 16'hFF);

        // Graceful stop requested during cnt=0: period completes, then idle
        run_seq("stop_pre", 1, 16'b1, 16'b1, 16'b0, 16'b1);
        en = 1'b0;
        run_seq("stop", 6, 16'b100000, 16'b0, 16'b0, 16'b111000);

        // Shadowed load P=5,H=1 issued at cnt=1
        en = 1'b1;
        run_seq("restart", 2, 16'b11, 16'b10, 16'b0, 16'b11);
        load(8'd5, 8'd1);
        run_seq("load51", 8, 16'b00100001, 16'b00100001, 16'b00100000, 16'hFF);

        // Clamp P=0,H=0 -> P=2,H=1
        load(8'd0, 8'd0);
        run_seq("clamp00", 8, 16'b00001010, 16'b00001010, 16'b00001000, 16'hFF);
        // Clamp P=5,H=9 -> H=4, loaded on a wrap edge
        load(8'd5, 8'd9);
        run_seq("clamp59", 7, 16'b1111011, 16'b1000010, 16'b1000000, 16'h7F);

        // Two loads in one period: last wins, one ack
        load(8'd6, 8'd3);
        run_seq("dbl_a", 1, 16'b1, 16'b0, 16'b0, 16'b1);
        load(8'd3, 8'd1);
        run_seq("dbl_b", 7, 16'b1010010, 16'b0010010, 16'b0010000, 16'h7F);
        run_seq("pre_wrap", 1, 16'b0, 16'b0, 16'b0, 16'b1);
        // Load on the wrap edge governs the very next period
        load(8'd8, 8'd4);
        run_seq("wrap_load", 9, 16'b111100001, 16'b100000001, 16'b100000000, 16'h1FF);

        // Reset in the high phase, then default pattern again
        reset = 1'b1;
        run_seq("mid_reset", 1, 16'b0, 16'b0, 16'b0, 16'b0);
        reset = 1'b0;
        run_seq("after_reset", 5, 16'b11001, 16'b10001, 16'b0, 16'h1F);

        // Loads while idle, and a load coinciding with en
        en = 1'b0; reset = 1'b1;
        run_seq("reset2", 1, 16'b0, 16'b0, 16'b0, 16'b0);
        reset = 1'b0;
        load(8'd3, 8'd2);
        run_seq("idle_load", 2, 16'b00, 16'b00, 16'b10, 16'b00);
        en = 1'b1;
        load(8'd6, 8'd1);
        run_seq("en_load", 7, 16'b1000001, 16'b1000001, 16'b1000000, 16'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
